mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter, minimum 8.
REQ-002 Parameter MEM_TIMEOUT, default 16: number of consecutive cycles without mem_ready before a timeout, minimum 1.
REQ-003 Port clk  in  1: the single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port start  in  1: leaves IDLE and begins fetching.
REQ-006 Port opcode  in  7: RV32I opcode field of the instruction register.
REQ-007 Port branch_taken  in  1: branch comparison result, sampled in EXECUTE.
REQ-008 Port mem_ready  in  1: memory completion handshake.
REQ-009 Port state_o  out  3: current state; IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, ERROR=6.
REQ-010 Port ir_write, pc_write, reg_write, mem_req, mem_we  out  1 each: datapath strobes.
REQ-011 Port pc_sel  out  2: 0=PC_PLUS_4, 1=PC_PLUS_IMM, 2=ALU_OUT.
REQ-012 Port halted, error  out  1 each; err_code  out  2 (0=none, 1=illegal opcode, 2=memory timeout).
REQ-013 Port retired_cnt  out  CNT_W: count of completed instructions.

Function
REQ-014 The FSM SHALL be Moore for state_o and mem_req; ir_write and pc_write may depend on mem_ready and branch_taken in the current cycle.
REQ-015 IDLE: all strobes low; start=1 goes to FETCH next cycle and clears halted.
REQ-016 FETCH: mem_req=1, mem_we=0; mem_ready=1 gives ir_write=1 that cycle and DECODE next.
REQ-017 DECODE: one cycle; the ten RV32I opcodes (R, I, LOAD, JALR, ENV, S, B, JAL, LUI, AUIPC) go to EXECUTE; any other opcode goes to ERROR with err_code=1.
REQ-018 EXECUTE, one cycle: LOAD/S go to MEM; R/I/JALR/JAL/LUI/AUIPC go to WRITEBACK.
REQ-019 EXECUTE, B-type: pc_write=1 with pc_sel=1 if branch_taken else 0; retire; FETCH next.
REQ-020 EXECUTE, ENV: retire; set halted=1; IDLE next.
REQ-021 MEM: mem_req=1 and mem_we=1 for S-type; on mem_ready, LOAD goes to WRITEBACK, while S-type asserts pc_write with pc_sel=0, retires and goes to FETCH.
REQ-022 WRITEBACK: reg_write=1 and pc_write=1 with pc_sel=1 for JAL, 2 for JALR, else 0; retire; FETCH next.
REQ-023 "Retire" SHALL increment retired_cnt by 1 at the clock edge ending that cycle, modulo 2^CNT_W (all-ones wraps to 0).
REQ-024 ERROR: all strobes low; error=1 and err_code held; exits only via rst; start is ignored.
REQ-025 The opcode input SHALL be sampled only in DECODE, EXECUTE, MEM and WRITEBACK; changes in other states have no effect.
REQ-026 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE and zero retired_cnt, halted, error, err_code and the timeout counter, from any state including mid-handshake; rst has priority over all transitions.
REQ-028 During reset and in the first cycle after it, all strobes SHALL be 0 and pc_sel SHALL be 0.

Configuration
REQ-029 Macro MC_MEM_TIMEOUT_EN SHALL gate the memory watchdog.
REQ-030 With the macro defined, a counter SHALL clear on entry to FETCH/MEM and increment on each cycle there with mem_ready=0; reaching MEM_TIMEOUT SHALL send the FSM to ERROR with err_code=2 on the next edge; mem_ready=1 in the cycle the limit is reached wins.
REQ-031 Without the macro, FETCH/MEM SHALL wait indefinitely, err_code=2 SHALL never occur, and the counter SHALL not be synthesised.

Verification
REQ-032 rst, start=1, R-type 0110011 with mem_ready=1 immediately -> states 1,2,3,5,1; reg_write=1 once; retired_cnt=1.
REQ-033 Store 0100011, with 3-cycle mem_ready delay in MEM -> mem_we=1 for 4 cycles; pc_sel=0; no reg_write; retired_cnt+1.
REQ-034 Branch 1100011 with branch_taken=1, then =0 -> pc_sel=1, then 0; each costs 3 cycles after fetch ready.
REQ-035 Opcode 1111111 -> ERROR, err_code=1, start ignored; rst -> IDLE, error=0.
REQ-036 MC_MEM_TIMEOUT_EN with MEM_TIMEOUT=4 and mem_ready held 0 in FETCH -> ERROR after 4 cycles, err_code=2; same test without the macro -> remains in FETCH for 100 cycles.
REQ-037 CNT_W=8, 256 retires of 0010011 -> retired_cnt wraps to 0; ECALL 1110011 -> halted=1, IDLE.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I control FSM; `define MC_MEM_TIMEOUT_EN enables the memory watchdog
module mc_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic [2:0]       state_o,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ENV   = 7'b1110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    if (CNT_W < 8) begin : g_cnt_w_chk
        $error("CNT_W must be at least 8");
    end
    if (MEM_TIMEOUT < 1) begin : g_tmo_chk
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_t state, state_n;
    logic   legal, retire, set_halt, tmo_hit;

    assign legal = opcode inside {OP_R, OP_I, OP_LOAD, OP_JALR, OP_ENV,
                                  OP_S, OP_B, OP_JAL, OP_LUI, OP_AUIPC};
    assign state_o = state;
    assign error   = (state == S_ERROR);

`ifdef MC_MEM_TIMEOUT_EN
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = !mem_ready && (tmo_cnt == TW'(MEM_TIMEOUT - 1));
    // watchdog: restarts on every state change, counts idle handshake cycles in FETCH/MEM
    always_ff @(posedge clk) begin
        if (rst || state_n != state || !(state == S_FETCH || state == S_MEM))
            tmo_cnt <= '0;
        else if (!mem_ready)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // state, retire counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            retired_cnt <= '0;
            halted      <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state <= state_n;
            if (retire)
                retired_cnt <= retired_cnt + 1'b1;
            if (state == S_IDLE && start)
                halted <= 1'b0;
            else if (set_halt)
                halted <= 1'b1;
            if (state != S_ERROR && state_n == S_ERROR)
                err_code <= (state == S_DECODE) ? 2'd1 : 2'd2;
        end
    end

    // next-state and datapath strobes; strobes forced low while rst is asserted
    always_comb begin
        state_n   = state;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        pc_sel    = 2'd0;
        retire    = 1'b0;
        set_halt  = 1'b0;
        case (state)
            S_IDLE: state_n = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                state_n  = mem_ready ? S_DECODE : (tmo_hit ? S_ERROR : S_FETCH);
            end
            S_DECODE: state_n = legal ? S_EXECUTE : S_ERROR;
            S_EXECUTE: begin
                if (opcode == OP_LOAD || opcode == OP_S) begin
                    state_n = S_MEM;
                end else if (opcode == OP_B) begin
                    pc_write = 1'b1;
                    pc_sel   = {1'b0, branch_taken};
                    retire   = 1'b1;
                    state_n  = S_FETCH;
                end else if (opcode == OP_ENV) begin
                    retire   = 1'b1;
                    set_halt = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_S);
                if (mem_ready) begin
                    pc_write = mem_we;
                    retire   = mem_we;
                    state_n  = mem_we ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_n = S_ERROR;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_sel    = (opcode == OP_JAL) ? 2'd1 : (opcode == OP_JALR) ? 2'd2 : 2'd0;
                retire    = 1'b1;
                state_n   = S_FETCH;
            end
            default: state_n = S_ERROR;
        endcase
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            pc_sel    = 2'd0;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;
    logic       clk = 1'b0;
    logic       rst, start, branch_taken, mem_ready;
    logic [6:0] opcode;
    logic [2:0] state_o;
    logic       ir_write, pc_write, reg_write, mem_req, mem_we;
    logic [1:0] pc_sel, err_code;
    logic       halted, error;
    logic [7:0] retired_cnt;
    int         passes = 0;
    int         total  = 0;

    mc_control_fsm #(.CNT_W(8), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .state_o(state_o),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .pc_sel(pc_sel), .halted(halted),
        .error(error), .err_code(err_code), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // fetch with immediate ready, then step through DECODE and EXECUTE
    task automatic fetch_to_exec(input logic [6:0] op);
        opcode    = op;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'b0110011;
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_strobes", {ir_write, pc_write, reg_write, mem_we}, 0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_state", state_o, 0);
        chk("post_rst_status", {halted, error, err_code}, 0);
        chk("post_rst_cnt", retired_cnt, 0);
        chk("post_rst_strobes", {ir_write, pc_write, reg_write, mem_req, mem_we, pc_sel}, 0);

        // R-type
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r_fetch_state", state_o, 1);
        mem_ready = 1'b1;
        settle();
        chk("r_fetch_irw", {mem_req, ir_write}, 2'b11);
        tick();
        mem_ready = 1'b0;
        chk("r_decode_state", state_o, 2);
        tick();
        chk("r_exec_state", state_o, 3);
        chk("r_exec_regw", reg_write, 0);
        tick();
        chk("r_wb_state", state_o, 5);
        chk("r_wb_strobes", {reg_write, pc_write, pc_sel}, 4'b1100);
        tick();
        chk("r_back_fetch", state_o, 1);
        chk("r_regw_off", reg_write, 0);
        chk("r_retired", retired_cnt, 1);

        // store with 3-cycle ready delay in MEM
        fetch_to_exec(7'b0100011);
        mem_ready = 1'b1;
        settle();
        chk("s_exec_ignores_ready", {state_o, pc_write, mem_we}, {3'd3, 2'b00});
        mem_ready = 1'b0;
        tick();
        chk("s_mem_state", state_o, 4);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            settle();
            chk("s_mem_we", {mem_req, mem_we, reg_write}, 3'b110);
            if (i == 3) chk("s_mem_pc", {pc_write, pc_sel}, 3'b100);
            tick();
        end
        mem_ready = 1'b0;
        chk("s_back_fetch", {state_o, mem_we}, {3'd1, 1'b0});
        chk("s_retired", retired_cnt, 2);

        // branches
        fetch_to_exec(7'b1100011);
        branch_taken = 1'b1;
        settle();
        chk("b_taken", {state_o, pc_write, pc_sel}, {3'd3, 3'b101});
        tick();
        chk("b_taken_fetch", state_o, 1);
        fetch_to_exec(7'b1100011);
        branch_taken = 1'b0;
        settle();
        chk("b_not_taken", {pc_write, pc_sel}, 3'b100);
        tick();
        chk("b_retired", {state_o, retired_cnt}, {3'd1, 8'd4});

        // JAL and JALR writeback pc_sel
        fetch_to_exec(7'b1101111);
        tick();
        chk("jal_wb", {state_o, pc_sel}, {3'd5, 2'd1});
        tick();
        fetch_to_exec(7'b1100111);
        tick();
        chk("jalr_wb", {state_o, pc_sel}, {3'd5, 2'd2});
        tick();

        // load: MEM without write, then WRITEBACK
        fetch_to_exec(7'b0000011);
        tick();
        mem_ready = 1'b1;
        settle();
        chk("ld_mem", {state_o, mem_req, mem_we, pc_write}, {3'd4, 3'b100});
        tick();
        mem_ready = 1'b0;
        chk("ld_wb", {state_o, reg_write}, {3'd5, 1'b1});
        tick();
        chk("ld_retired", retired_cnt, 7);

        // counter wrap with I-type
        for (int i = 0; i < 248; i++) begin
            fetch_to_exec(7'b0010011);
            tick();
            tick();
        end
        chk("cnt_255", retired_cnt, 255);
        fetch_to_exec(7'b0010011);
        tick();
        tick();
        chk("cnt_wrap", retired_cnt, 0);

        // ECALL halts
        fetch_to_exec(7'b1110011);
        tick();
        chk("ecall_idle", {state_o, halted}, {3'd0, 1'b1});
        chk("ecall_retired", retired_cnt, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clears_halt", {state_o, halted}, {3'd1, 1'b0});

        // illegal opcode
        fetch_to_exec(7'b1111111);
        chk("ill_error", {state_o, error, err_code}, {3'd6, 1'b1, 2'd1});
        chk("ill_strobes", {ir_write, pc_write, reg_write, mem_req, mem_we}, 0);
        start = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        start = 1'b0;
        mem_ready = 1'b0;
        chk("ill_sticky", {state_o, err_code}, {3'd6, 2'd1});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ill_rst", {state_o, error, err_code, retired_cnt}, 0);

        // memory watchdog
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MC_MEM_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("tmo_still_fetch", state_o, 1);
        tick();
        chk("tmo_error", {state_o, error, err_code}, {3'd6, 1'b1, 2'd2});
`else
        begin
            int left = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (state_o != 3'd1 || error) left++;
            end
            chk("no_tmo_stays_fetch", left, 0);
            chk("no_tmo_status", {state_o, err_code, mem_req}, {3'd1, 2'd0, 1'b1});
        end
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
